// File: rtl/plu_pkg.sv
// Shared FSM encoding, MAC/header geometry and word-to-field placement for the PLU header extractor.
// Header words are big-endian: word0 -> DA[47:16], word1 -> DA[15:0]|SA[47:32], word2 -> SA[31:0].
package plu_pkg;

  localparam int MAC_W     = 48;
  localparam int WORD_W    = 32;
  localparam int HDR_WORDS = 3;
  localparam int DA_W0_LSB = 16;
  localparam int SPLIT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_BODY    = 3'd2,
    ST_REQ     = 3'd3,
    ST_DISCARD = 3'd4
  } plu_state_t;

  typedef struct packed {
    logic [MAC_W-1:0] da;
    logic [MAC_W-1:0] sa;
  } mac_pair_t;

  function automatic mac_pair_t place_word(input mac_pair_t cur, input logic [1:0] idx,
                                           input logic [WORD_W-1:0] w);
    mac_pair_t r;
    r = cur;
    case (idx)
      2'd0: r.da[MAC_W-1:DA_W0_LSB] = w;
      2'd1: begin
        r.da[SPLIT_W-1:0]             = w[WORD_W-1:SPLIT_W];
        r.sa[MAC_W-1:MAC_W-SPLIT_W]   = w[SPLIT_W-1:0];
      end
      default: r.sa[WORD_W-1:0] = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/plu_header_extract_if.sv
// Crossbar word stream in, PLU lookup request out (valid/ready); master drives the stream and ready.
// No storage here; timing is defined entirely by the extractor behind the slave modport.
interface plu_header_extract_if #(
  parameter int PORT_W = 2,
  parameter int LEN_W  = 10
);
  logic [31:0]              xbar2plu_data;
  logic                     xbar2plu_start_pack;
  logic                     xbar2plu_end_pack;
  logic                     plu_req_valid;
  logic                     plu_req_ready;
  logic [plu_pkg::MAC_W-1:0] plu_da;
  logic [plu_pkg::MAC_W-1:0] plu_sa;
  logic [PORT_W-1:0]        plu_src_port;
  logic [LEN_W-1:0]         plu_len_words;
  logic                     plu_runt;
  logic                     plu_abort;
  logic                     plu_drop;

  modport master (
    output xbar2plu_data, xbar2plu_start_pack, xbar2plu_end_pack, plu_req_ready,
    input  plu_req_valid, plu_da, plu_sa, plu_src_port, plu_len_words, plu_runt,
           plu_abort, plu_drop
  );

  modport slave (
    input  xbar2plu_data, xbar2plu_start_pack, xbar2plu_end_pack, plu_req_ready,
    output plu_req_valid, plu_da, plu_sa, plu_src_port, plu_len_words, plu_runt,
           plu_abort, plu_drop
  );
endinterface

// File: rtl/plu_sat_counter.sv
// Saturating up-counter, 1-cycle update; clear with inc loads 1 so a new count can start in place.
// Holds at all-ones rather than wrapping; no backpressure.
module plu_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= W'(i_inc);
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/plu_header_extract.sv
// Per-packet DA/SA/length capture into one PLU request; valid rises the cycle after end_pack, held until ready.
// A packet starting under a stalled request is dropped; PLU_HDR_STATS_EN adds 16-bit saturating stat counters.
module plu_header_extract
  import plu_pkg::*;
#(
  parameter int SRC_PORT = 0,
  parameter int PORT_W   = 2,
  parameter int LEN_W    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  plu_header_extract_if.slave  io
`ifdef PLU_HDR_STATS_EN
  ,
  output logic [15:0]          stat_pkts,
  output logic [15:0]          stat_runts,
  output logic [15:0]          stat_aborts,
  output logic [15:0]          stat_drops
`endif
);
  localparam logic [1:0] HDR_LAST = 2'(HDR_WORDS - 1);

  plu_state_t       r_state, w_state_nxt;
  mac_pair_t        r_mac, w_mac_nxt;
  logic [1:0]       r_hdr_cnt, w_hdr_cnt_nxt;
  logic             r_runt, w_runt_nxt;
  logic             r_pend, w_pend_nxt;
  logic             r_abort, r_drop;
  logic             w_abort, w_drop;
  logic             w_len_clr, w_len_inc;
  logic             w_start_new;
  logic             w_valid, w_hs;
  logic             w_sop, w_eop;
  logic [31:0]      w_dat;
  logic [LEN_W-1:0] w_len;

  assign w_sop   = io.xbar2plu_start_pack;
  assign w_eop   = io.xbar2plu_end_pack;
  assign w_dat   = io.xbar2plu_data;
  // A request parked behind a discarded packet is still offered to the PLU.
  assign w_valid = (r_state == ST_REQ) || ((r_state == ST_DISCARD) && r_pend);
  assign w_hs    = w_valid && io.plu_req_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_mac_nxt     = r_mac;
    w_hdr_cnt_nxt = r_hdr_cnt;
    w_runt_nxt    = r_runt;
    w_pend_nxt    = r_pend;
    w_len_clr     = 1'b0;
    w_len_inc     = 1'b0;
    w_abort       = 1'b0;
    w_drop        = 1'b0;
    w_start_new   = 1'b0;
    unique case (r_state)
      ST_IDLE: w_start_new = w_sop;
      ST_HDR, ST_BODY: begin
        if (w_sop) begin
          w_start_new = 1'b1;
          w_abort     = 1'b1;
        end else begin
          w_len_inc = 1'b1;
          if (r_state == ST_HDR) begin
            w_mac_nxt     = place_word(r_mac, r_hdr_cnt, w_dat);
            w_hdr_cnt_nxt = r_hdr_cnt + 2'd1;
            if (w_eop) begin
              w_state_nxt = ST_REQ;
              w_runt_nxt  = (r_hdr_cnt != HDR_LAST);
            end else if (r_hdr_cnt == HDR_LAST) begin
              w_state_nxt = ST_BODY;
            end
          end else if (w_eop) begin
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (io.plu_req_ready) begin
          w_state_nxt = ST_IDLE;
          w_start_new = w_sop;
        end else if (w_sop) begin
          w_drop = 1'b1;
          if (!w_eop) begin
            w_state_nxt = ST_DISCARD;
            w_pend_nxt  = 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        if (w_hs) w_pend_nxt = 1'b0;
        if (w_eop) w_state_nxt = (r_pend && !w_hs) ? ST_REQ : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Fresh capture overrides whatever the current state decided for the fields.
    if (w_start_new) begin
      w_mac_nxt     = place_word('0, 2'd0, w_dat);
      w_len_clr     = 1'b1;
      w_len_inc     = 1'b1;
      w_hdr_cnt_nxt = 2'd1;
      w_runt_nxt    = w_eop;
      w_state_nxt   = w_eop ? ST_REQ : ST_HDR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_mac     <= '0;
      r_hdr_cnt <= '0;
      r_runt    <= 1'b0;
      r_pend    <= 1'b0;
      r_abort   <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mac     <= w_mac_nxt;
      r_hdr_cnt <= w_hdr_cnt_nxt;
      r_runt    <= w_runt_nxt;
      r_pend    <= w_pend_nxt;
      r_abort   <= w_abort;
      r_drop    <= w_drop;
    end
  end

  plu_sat_counter #(.W(LEN_W)) u_len (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_len_clr),
    .i_inc (w_len_inc),
    .o_cnt (w_len)
  );

  assign io.plu_req_valid = w_valid;
  assign io.plu_da        = r_mac.da;
  assign io.plu_sa        = r_mac.sa;
  assign io.plu_src_port  = PORT_W'(SRC_PORT);
  assign io.plu_len_words = w_len;
  assign io.plu_runt      = r_runt;
  assign io.plu_abort     = r_abort;
  assign io.plu_drop      = r_drop;

`ifdef PLU_HDR_STATS_EN
  logic w_runt_evt;
  assign w_runt_evt = (w_state_nxt == ST_REQ) && w_runt_nxt &&
                      (w_start_new || (r_state == ST_HDR));

  plu_sat_counter #(.W(16)) u_stat_pkts (
    .clk(clk), .rst_n(reset), .i_clr(1'b0), .i_inc(w_hs), .o_cnt(stat_pkts));
  plu_sat_counter #(.W(16)) u_stat_runts (
    .clk(clk), .rst_n(reset), .i_clr(1'b0), .i_inc(w_runt_evt), .o_cnt(stat_runts));
  plu_sat_counter #(.W(16)) u_stat_aborts (
    .clk(clk), .rst_n(reset), .i_clr(1'b0), .i_inc(w_abort), .o_cnt(stat_aborts));
  plu_sat_counter #(.W(16)) u_stat_drops (
    .clk(clk), .rst_n(reset), .i_clr(1'b0), .i_inc(w_drop), .o_cnt(stat_drops));
`endif

endmodule

// File: tb/tb_plu_header_extract.sv
// Bench for plu_header_extract: directed scenarios plus randomized packets against a packet-level model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_plu_header_extract;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   abort_seen = 0;
  int   drop_seen  = 0;
  logic [31:0] pkt [0:1099];

  plu_header_extract_if #(.PORT_W(2), .LEN_W(10)) io ();

  plu_header_extract #(.SRC_PORT(0), .PORT_W(2), .LEN_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (io.plu_abort === 1'b1) abort_seen++;
    if (io.plu_drop === 1'b1) drop_seen++;
  end

  // {valid, DA, SA, len, runt}
  function automatic logic [107:0] observe();
    return {io.plu_req_valid, io.plu_da, io.plu_sa, io.plu_len_words, io.plu_runt};
  endfunction

  // Expected request for an n-word packet held in pkt[]: header bytes are the first
  // 12 bytes of the packet (missing words read as zero), length saturates at 1023.
  function automatic logic [107:0] model_req(input int n);
    logic [31:0] h [3];
    logic [95:0] hdr;
    logic [9:0]  len;
    for (int k = 0; k < 3; k++) h[k] = (k < n) ? pkt[k] : 32'h0;
    hdr = {h[0], h[1], h[2]};
    len = (n > 1023) ? 10'd1023 : 10'(n);
    return {1'b1, hdr, len, (n < 3)};
  endfunction

  function automatic void fill(input int n);
    for (int k = 0; k < n; k++) pkt[k] = $urandom;
  endfunction

  task automatic drive_pkt(input int n, input bit close);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      io.xbar2plu_data       = pkt[i];
      io.xbar2plu_start_pack = (i == 0);
      io.xbar2plu_end_pack   = close && (i == n - 1);
    end
  endtask

  task automatic next_idle();
    @(negedge clk);
    io.xbar2plu_start_pack = 1'b0;
    io.xbar2plu_end_pack   = 1'b0;
    io.xbar2plu_data       = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    io.xbar2plu_data       = '0;
    io.xbar2plu_start_pack = 1'b0;
    io.xbar2plu_end_pack   = 1'b0;
    io.plu_req_ready       = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (observe() !== 108'h0) begin
      n_fail++; $display("FAIL reset_req obs=%h exp=0", observe());
    end
    n_checks++;
    if ({io.plu_abort, io.plu_drop} !== 2'b00) begin
      n_fail++; $display("FAIL reset_pulses obs=%b exp=00", {io.plu_abort, io.plu_drop});
    end
    n_checks++;
    if (io.plu_src_port !== 2'd0) begin
      n_fail++; $display("FAIL reset_src_port obs=%0d exp=0", io.plu_src_port);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (observe() !== 108'h0) begin
      n_fail++; $display("FAIL post_reset_idle obs=%h exp=0", observe());
    end
  endtask

  task automatic test_nominal();
    logic [107:0] e_req;
    io.plu_req_ready = 1'b1;
    pkt[0] = 32'h00112233; pkt[1] = 32'h44558899; pkt[2] = 32'hAABBCCDD;
    pkt[3] = $urandom;     pkt[4] = $urandom;
    e_req = model_req(5);
    drive_pkt(5, 1'b1);
    n_checks++;
    if (io.plu_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL nominal_early_valid obs=%b exp=0", io.plu_req_valid);
    end
    next_idle();
    n_checks++;
    if (observe() !== e_req) begin
      n_fail++; $display("FAIL nominal_req obs=%h exp=%h", observe(), e_req);
    end
    n_checks++;
    if (io.plu_da !== 48'h001122334455 || io.plu_sa !== 48'h8899AABBCCDD) begin
      n_fail++; $display("FAIL nominal_macs da=%h sa=%h exp da=001122334455 sa=8899aabbccdd",
                         io.plu_da, io.plu_sa);
    end
    @(negedge clk);
    n_checks++;
    if (io.plu_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL nominal_release obs=%b exp=0", io.plu_req_valid);
    end
  endtask

  task automatic test_short(input int n, input string name);
    logic [107:0] e_req;
    io.plu_req_ready = 1'b1;
    fill(n);
    e_req = model_req(n);
    drive_pkt(n, 1'b1);
    next_idle();
    n_checks++;
    if (observe() !== e_req) begin
      n_fail++; $display("FAIL %s_req obs=%h exp=%h", name, observe(), e_req);
    end
    n_checks++;
    if (io.plu_sa[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL %s_sa_low obs=%h exp=0", name, io.plu_sa[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [107:0] e_req;
    io.plu_req_ready = 1'b1;
    fill(1030);
    e_req = model_req(1030);
    drive_pkt(1030, 1'b1);
    next_idle();
    n_checks++;
    if (observe() !== e_req) begin
      n_fail++; $display("FAIL saturation_req obs=%h exp=%h", observe(), e_req);
    end
    n_checks++;
    if (io.plu_len_words !== 10'h3FF) begin
      n_fail++; $display("FAIL saturation_len obs=%0d exp=1023", io.plu_len_words);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [107:0] e_a;
    int d0;
    io.plu_req_ready = 1'b0;
    fill(5);
    e_a = model_req(5);
    d0  = drop_seen;
    drive_pkt(5, 1'b1);
    next_idle();
    fill(4);
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (observe() !== e_a) begin
        n_fail++; $display("FAIL bp_hold cycle=%0d obs=%h exp=%h", c, observe(), e_a);
      end
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        io.xbar2plu_data       = pkt[c-2];
        io.xbar2plu_start_pack = (c == 2);
        io.xbar2plu_end_pack   = (c == 5);
      end else begin
        io.xbar2plu_data       = $urandom;
        io.xbar2plu_start_pack = 1'b0;
        io.xbar2plu_end_pack   = 1'b0;
      end
    end
    n_checks++;
    if (observe() !== e_a) begin
      n_fail++; $display("FAIL bp_before_ready obs=%h exp=%h", observe(), e_a);
    end
    io.plu_req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (io.plu_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release obs=%b exp=0", io.plu_req_valid);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (io.plu_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL bp_second_pkt cycle=%0d valid=%b exp=0", c, io.plu_req_valid);
      end
    end
    n_checks++;
    if (drop_seen - d0 !== 1) begin
      n_fail++; $display("FAIL bp_drop_count obs=%0d exp=1", drop_seen - d0);
    end
  endtask

  task automatic test_restart();
    logic [107:0] e_b;
    int a0;
    io.plu_req_ready = 1'b1;
    a0 = abort_seen;
    fill(4);
    drive_pkt(4, 1'b0);
    fill(6);
    e_b = model_req(6);
    drive_pkt(6, 1'b1);
    next_idle();
    n_checks++;
    if (observe() !== e_b) begin
      n_fail++; $display("FAIL restart_req obs=%h exp=%h", observe(), e_b);
    end
    @(negedge clk);
    n_checks++;
    if (abort_seen - a0 !== 1) begin
      n_fail++; $display("FAIL restart_abort_count obs=%0d exp=1", abort_seen - a0);
    end
  endtask

  task automatic test_reset_mid();
    io.plu_req_ready = 1'b1;
    fill(5);
    drive_pkt(5, 1'b0);
    next_idle();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({observe(), io.plu_abort, io.plu_drop} !== 110'h0) begin
      n_fail++; $display("FAIL reset_mid_async obs=%h exp=0", observe());
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    io.xbar2plu_end_pack = 1'b1;
    io.xbar2plu_data     = $urandom;
    @(negedge clk);
    io.xbar2plu_end_pack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (observe() !== 108'h0) begin
        n_fail++; $display("FAIL reset_mid_lone_eop cycle=%0d obs=%h exp=0", c, observe());
      end
    end
  endtask

  task automatic test_random();
    logic [107:0] exp_q [$];
    logic [107:0] e_req;
    int  sent = 0, cyc = 0, n = 0, i = 0, a0, d0;
    bit  in_pkt = 1'b0;
    a0 = abort_seen;
    d0 = drop_seen;
    while ((sent < 40 || in_pkt || exp_q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      io.plu_req_ready = ($urandom_range(0, 2) != 0);
      if (io.plu_req_valid && io.plu_req_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL random_unexpected_req obs=%h exp=none", observe());
        end else begin
          e_req = exp_q.pop_front();
          if (observe() !== e_req) begin
            n_fail++; $display("FAIL random_req obs=%h exp=%h", observe(), e_req);
          end
        end
      end
      io.xbar2plu_start_pack = 1'b0;
      io.xbar2plu_end_pack   = 1'b0;
      io.xbar2plu_data       = $urandom;
      if (in_pkt) begin
        io.xbar2plu_data     = pkt[i];
        io.xbar2plu_end_pack = (i == n - 1);
        if (i == n - 1) in_pkt = 1'b0;
        i++;
      end else if (sent < 40 && (!io.plu_req_valid || io.plu_req_ready) &&
                   ($urandom_range(0, 1) == 1)) begin
        n = $urandom_range(1, 8);
        fill(n);
        exp_q.push_back(model_req(n));
        io.xbar2plu_data       = pkt[0];
        io.xbar2plu_start_pack = 1'b1;
        io.xbar2plu_end_pack   = (n == 1);
        in_pkt = (n > 1);
        i = 1;
        sent++;
      end
    end
    n_checks++;
    if (cyc >= 5000 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_drain cycles=%0d pending=%0d exp pending=0", cyc, exp_q.size());
    end
    n_checks++;
    if ((abort_seen - a0) !== 0 || (drop_seen - d0) !== 0) begin
      n_fail++; $display("FAIL random_pulses aborts=%0d drops=%0d exp 0/0",
                         abort_seen - a0, drop_seen - d0);
    end
    io.plu_req_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short(2, "runt");
    test_short(1, "single");
    test_backpressure();
    test_restart();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plu_header_extract.md
Name: plu_header_extract

Overview:
- Downstream neighbour of the crossbar alignment stage.
- Consumes the 32-bit word stream framed by xbar2plu_start_pack/xbar2plu_end_pack.
- Captures destination/source MAC from the first three words and counts packet length in words.
- Presents one lookup request per packet to the packet lookup unit (PLU) over a valid/ready handshake.

Parameters:
- SRC_PORT, 0, crossbar port number stamped on every request
- PORT_W, 2, width of plu_src_port
- LEN_W, 10, width of the word counter (saturating)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- xbar2plu_data  input  32  packet word; valid every cycle from start_pack to end_pack inclusive
- xbar2plu_start_pack  input  1  first-word marker
- xbar2plu_end_pack  input  1  last-word marker
- plu_req_valid  output  1  request pending
- plu_req_ready  input  1  PLU accepts request when high with valid
- plu_da  output  48  destination MAC
- plu_sa  output  48  source MAC
- plu_src_port  output  PORT_W  equals SRC_PORT
- plu_len_words  output  LEN_W  packet length in words, inclusive
- plu_runt  output  1  packet shorter than 3 words (header incomplete)
- plu_abort  output  1  one-cycle pulse: packet abandoned by a new start_pack
- plu_drop  output  1  one-cycle pulse: packet dropped because a request was still pending

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0; plu_src_port=SRC_PORT.
- Word mapping (big-endian):
  - word0 → DA[47:16].
  - word1[31:16] → DA[15:0]; word1[15:0] → SA[47:32].
  - word2 → SA[31:0].
- FSM states: IDLE, HDR, BODY, REQ, DISCARD.
- IDLE:
  - start_pack → capture word0; len=1.
  - Go to HDR (hdr_cnt=1), or straight to REQ if end_pack is also high (runt, len=1).
- HDR:
  - Each cycle captures word hdr_cnt; len+1.
  - After word2 go to BODY.
  - end_pack in HDR → REQ with plu_runt=1; uncaptured fields hold 0.
- BODY:
  - len+1 per cycle.
  - end_pack → REQ.
- REQ:
  - plu_req_valid=1; DA/SA/len/runt held stable until handshake.
  - Handshake (valid&ready) → IDLE, valid falls next cycle.
- Simultaneous events:
  - start_pack in HDR/BODY without end → plu_abort pulse; restart capture with this word as word0 (len=1).
  - start_pack in REQ with ready=1 → request completes and the new packet is captured in the same cycle.
  - start_pack in REQ with ready=0 → plu_drop pulse; go to DISCARD and remember the pending request (valid stays high).
- DISCARD:
  - Ignores words until end_pack, then returns to REQ, or IDLE if the handshake happened meanwhile.
  - start+end together in REQ/ready=0 → drop pulse, remain REQ.
- Length arithmetic:
  - Counter saturates at 2^LEN_W-1; never wraps.
- Latency:
  - plu_req_valid rises the cycle after end_pack is sampled.
- Reset mid-packet or mid-request:
  - Everything clears; the next valid activity is the next start_pack.
  - end_pack in IDLE is ignored.

Optional Feature:
- Macro PLU_HDR_STATS_EN.
- With the macro: adds 16-bit saturating output counters, cleared by reset:
  - stat_pkts (handshakes)
  - stat_runts
  - stat_aborts
  - stat_drops
- Without the macro: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package plu_pkg holds:
  - FSM state encoding localparams (IDLE..DISCARD)
  - MAC_W=48
  - word-offset constants HDR_WORDS=3
  - the word-to-field mapping constants
- One natural sub-module: plu_sat_counter (parameterised width, inc, clear), used for the length counter and the statistics counters.

Test Plan:
- Nominal packet: 5-word packet, words 0x00112233, 0x44558899, 0xAABBCCDD, then 2 payload words, ready=1 → one request; DA=0x001122334455, SA=0x8899AABBCCDD, len=5, runt=0.
- Runt packet: 2-word packet with start and end 1 cycle apart → request with len=2, runt=1, SA[31:0]=0.
- Single-word packet: start and end in the same cycle → len=1, runt=1.
- Backpressure drop: ready=0 held 20 cycles, a second packet starts during REQ → plu_drop pulses once; first request data unchanged until ready=1; second packet produces no request.
- Mid-packet restart: start_pack at word 4 of a packet → plu_abort pulse; the following request reflects only the new packet's header and length.
- Reset during BODY: reset asserted → outputs 0 immediately, without waiting for a clock edge; after release, end_pack alone produces no request.
